// File: rtl/clock_reset_ctrl.sv
// Clock/reset controller: lock qualification, reset sequencing and CPU
// clock-enable generation (free-run divider or single-step).
module clock_reset_ctrl #(
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int RESET_HOLD_CYCLES  = 16,
    parameter int CLK_DIV            = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       run_mode,
    input  logic       step_btn,
    input  logic       halt,
    output logic       sys_reset,
    output logic       cpu_clk_en,
    output logic       ready,
    output logic [1:0] state
);

    localparam int MAX_CNT = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ?
                             LOCK_STABLE_CYCLES : RESET_HOLD_CYCLES;
    localparam int CW = $clog2(MAX_CNT + 1);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(RESET_HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        WAIT_LOCK  = 2'd0,
        STABILIZE  = 2'd1,
        HOLD_RESET = 2'd2,
        RUN        = 2'd3
    } state_t;

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [DW-1:0] r_div;
    logic          r_mode_q;
    logic          r_step_prev;
    logic          r_step_pulse;
    logic          w_lock_sync;
    logic          w_run;
    logic          w_div_clr;
    logic          w_free_hit;
    logic          w_step_edge;

    assign w_lock_sync = r_sync2;
    assign w_run       = (r_state == RUN);

    // Two-flop synchronizer bringing the PLL lock flag into clk
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    // State and qualification counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= WAIT_LOCK;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic; loss of lock wins over every other transition
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            WAIT_LOCK: begin
                w_cnt_next = '0;
                if (w_lock_sync) w_state_next = STABILIZE;
            end
            STABILIZE: begin
                if (!w_lock_sync) begin
                    w_state_next = WAIT_LOCK;
                    w_cnt_next   = '0;
                end else if (r_cnt == LOCK_LAST) begin
                    w_state_next = HOLD_RESET;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            HOLD_RESET: begin
                if (!w_lock_sync) begin
                    w_state_next = WAIT_LOCK;
                    w_cnt_next   = '0;
                end else if (r_cnt == HOLD_LAST) begin
                    w_state_next = RUN;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + CW'(1);
                end
            end
            RUN: begin
                w_cnt_next = '0;
                if (!w_lock_sync) w_state_next = WAIT_LOCK;
            end
            default: begin
                w_state_next = WAIT_LOCK;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign w_div_clr = !w_run || halt || !run_mode;

    // Free-run divider; held at zero outside active free-running
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
        end else if (w_div_clr) begin
            r_div <= '0;
        end else if (r_div == DIV_LAST) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // Registered mode so a mode switch only changes strobes next cycle
    always_ff @(posedge clk) begin
        if (reset) r_mode_q <= 1'b0;
        else       r_mode_q <= run_mode;
    end

    assign w_step_edge = step_btn && !r_step_prev;

    // Step edge detector; prev preset to 1 so a held button never fires
    always_ff @(posedge clk) begin
        if (reset) begin
            r_step_prev  <= 1'b1;
            r_step_pulse <= 1'b0;
        end else begin
            r_step_prev  <= step_btn;
            r_step_pulse <= w_run && !halt && !run_mode && w_step_edge;
        end
    end

    assign w_free_hit = r_mode_q && (r_div == DIV_LAST);
    assign cpu_clk_en = w_run && !halt && (w_free_hit || r_step_pulse);
    assign sys_reset  = !w_run;
    assign ready      = w_run;
    assign state      = r_state;

endmodule

// File: tb/tb_clock_reset_ctrl.sv
// Randomized scoreboard bench for clock_reset_ctrl against a
// lock-streak / run-streak reference model.
module tb_clock_reset_ctrl;

    localparam int LOCK = 4;
    localparam int HOLD = 3;
    localparam int DIV  = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_locked = 1'b0;
    logic       run_mode = 1'b0;
    logic       step_btn = 1'b1;
    logic       halt = 1'b0;
    logic       sys_reset;
    logic       cpu_clk_en;
    logic       ready;
    logic [1:0] state;

    clock_reset_ctrl #(
        .LOCK_STABLE_CYCLES(LOCK),
        .RESET_HOLD_CYCLES (HOLD),
        .CLK_DIV           (DIV)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pll_locked(pll_locked),
        .run_mode  (run_mode),
        .step_btn  (step_btn),
        .halt      (halt),
        .sys_reset (sys_reset),
        .cpu_clk_en(cpu_clk_en),
        .ready     (ready),
        .state     (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic       rst;
        logic       rdy;
        logic       en;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Model: m_seq counts consecutive edges that saw synchronized lock;
    // the phase follows from how long that streak has lasted.
    int   m_seq      = 0;
    logic m_p1       = 1'b0;
    logic m_lsync    = 1'b0;
    logic m_prev_btn = 1'b1;
    logic m_step     = 1'b0;
    logic m_mode     = 1'b0;
    int   m_streak   = 0;

    function automatic logic [1:0] phase_of(input int seq);
        if (seq == 0)              return 2'd0;
        else if (seq <= LOCK)      return 2'd1;
        else if (seq <= LOCK+HOLD) return 2'd2;
        else                       return 2'd3;
    endfunction

    always @(posedge clk) begin
        logic was_run;
        logic [1:0] ph;
        exp_t e;
        was_run = (phase_of(m_seq) == 2'd3);
        if (reset) begin
            m_seq      = 0;
            m_p1       = 1'b0;
            m_lsync    = 1'b0;
            m_prev_btn = 1'b1;
            m_step     = 1'b0;
            m_mode     = 1'b0;
            m_streak   = 0;
        end else begin
            m_step     = was_run && !halt && !run_mode
                         && step_btn && !m_prev_btn;
            m_prev_btn = step_btn;
            m_streak   = (was_run && !halt && run_mode) ? m_streak + 1 : 0;
            m_mode     = run_mode;
            if (m_lsync) m_seq = (m_seq < 1000) ? m_seq + 1 : m_seq;
            else         m_seq = 0;
            m_lsync    = m_p1;
            m_p1       = pll_locked;
        end
        #3;
        ph    = phase_of(m_seq);
        e.st  = ph;
        e.rst = (ph != 2'd3);
        e.rdy = (ph == 2'd3);
        e.en  = (ph == 2'd3) && !halt &&
                ((m_mode && (m_streak % DIV) == DIV - 1) || m_step);
        sb_q.push_back(e);
    end

    task automatic check(input string name, input logic [1:0] got,
                         input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("state", state, e.st);
            check("sys_reset", {1'b0, sys_reset}, {1'b0, e.rst});
            check("ready", {1'b0, ready}, {1'b0, e.rdy});
            check("cpu_clk_en", {1'b0, cpu_clk_en}, {1'b0, e.en});
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        // reset with step button held, then lock and run while still held
        wait_cyc(3);
        reset      = 1'b0;
        pll_locked = 1'b1;
        wait_cyc(20);
        // release and re-press: one strobe
        step_btn = 1'b0;
        wait_cyc(2);
        step_btn = 1'b1;
        wait_cyc(5);
        step_btn = 1'b0;
        wait_cyc(2);
        // edge during halt is discarded
        halt     = 1'b1;
        step_btn = 1'b1;
        wait_cyc(2);
        halt = 1'b0;
        wait_cyc(3);
        step_btn = 1'b0;
        wait_cyc(2);
        // free run with a 10-cycle halt
        run_mode = 1'b1;
        wait_cyc(12);
        halt = 1'b1;
        wait_cyc(10);
        halt = 1'b0;
        wait_cyc(10);
        // lock drop in RUN, then a glitch during stabilize
        pll_locked = 1'b0;
        wait_cyc(1);
        pll_locked = 1'b1;
        wait_cyc(4);
        pll_locked = 1'b0;
        wait_cyc(1);
        pll_locked = 1'b1;
        wait_cyc(20);
        // reset mid-run
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        wait_cyc(15);
        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            reset      = ($urandom_range(0, 599) == 0);
            pll_locked = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 7) == 0)  halt     = ~halt;
            if ($urandom_range(0, 39) == 0) run_mode = ~run_mode;
            if ($urandom_range(0, 2) == 0)  step_btn = ~step_btn;
            wait_cyc(1);
        end
        reset = 1'b0;
        wait_cyc(2);
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_reset_ctrl.md
CLOCK_RESET_CTRL -- requirements
Module: clock_reset_ctrl

Interface
REQ-001 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive cycles of synchronized lock required before reset release (>=1).
REQ-002 SHALL have parameter RESET_HOLD_CYCLES, default 16: cycles sys_reset stays high after lock qualified (>=1).
REQ-003 SHALL have parameter CLK_DIV, default 4: free-run CPU clock-enable period in clk cycles (>=1).
REQ-004 SHALL have port clk  input  1  system clock (PLL output domain); single clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port pll_locked  input  1  PLL lock flag, asynchronous to clk.
REQ-007 SHALL have port run_mode  input  1  1 = free-run, 0 = single-step.
REQ-008 SHALL have port step_btn  input  1  debounced, clk-synchronous step request level.
REQ-009 SHALL have port halt  input  1  CPU halt; suppresses all CPU clock enables.
REQ-010 SHALL have port sys_reset  output  1  active-high reset to downstream logic.
REQ-011 SHALL have port cpu_clk_en  output  1  one-cycle CPU advance strobe.
REQ-012 SHALL have port ready  output  1  high only in RUN.
REQ-013 SHALL have port state  output  2  current FSM state encoding.

Function
REQ-014 SHALL pass pll_locked through a 2-flop synchronizer; the second flop output is lock_sync.
REQ-015 SHALL implement states WAIT_LOCK=0, STABILIZE=1, HOLD_RESET=2, RUN=3, driven on state.
REQ-016 WAIT_LOCK: counter cleared; lock_sync=1 -> STABILIZE at next edge.
REQ-017 STABILIZE: SHALL remain exactly LOCK_STABLE_CYCLES cycles while lock_sync=1, then -> HOLD_RESET with counter cleared.
REQ-018 HOLD_RESET: SHALL remain exactly RESET_HOLD_CYCLES cycles, then -> RUN.
REQ-019 lock_sync=0 in STABILIZE, HOLD_RESET or RUN SHALL force WAIT_LOCK at next edge and clear counter; this overrides any other transition in the same cycle.
REQ-020 sys_reset SHALL be high in every state except RUN; ready SHALL be high only in RUN; both SHALL be decoded from registered state only (no combinational input path).
REQ-021 cpu_clk_en SHALL be 0 whenever state!=RUN or halt=1.
REQ-022 Free-run (run_mode=1): divider counts 0..CLK_DIV-1; cpu_clk_en high for one cycle when divider=CLK_DIV-1; CLK_DIV=1 -> cpu_clk_en continuously high.
REQ-023 Divider SHALL clear on entry to RUN, while halt=1, and while run_mode=0; first strobe after release occurs CLK_DIV cycles later.
REQ-024 Step (run_mode=0): a step_btn rising edge (step_btn=1, previous sample 0) SHALL produce exactly one cpu_clk_en cycle at the next edge; a held button produces no further strobes.
REQ-025 Step edges occurring while halt=1 or state!=RUN SHALL be discarded, not queued.
REQ-026 run_mode change SHALL take effect next cycle with no extra or truncated strobe beyond REQ-023/024.
REQ-027 Counter width SHALL hold max(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES) without wrap.

Reset
REQ-028 reset=1 at a clk edge SHALL set state=WAIT_LOCK, clear synchronizer, counter and divider, set step previous-sample flop to 1.
REQ-029 During and after reset: sys_reset=1, ready=0, cpu_clk_en=0, state=0.
REQ-030 reset asserted mid-sequence (any state) SHALL restart the full lock-qualification sequence.
REQ-031 step_btn held high through reset SHALL NOT generate a step strobe.

Verification
REQ-032 LOCK_STABLE_CYCLES=4, RESET_HOLD_CYCLES=3: pll_locked rises before edge E0 -> sys_reset falls, ready rises after edge E9; state sequence 0,1,2,3.
REQ-033 Same params: pll_locked low for 1 cycle during STABILIZE -> state returns to 0, full 4-cycle stabilize recounted; sys_reset never drops early.
REQ-034 RUN, CLK_DIV=4, run_mode=1: cpu_clk_en pulses every 4th cycle; halt=1 for 10 cycles -> no pulses; after release next pulse exactly 4 cycles later.
REQ-035 RUN, run_mode=0: step_btn high 5 cycles -> exactly one cpu_clk_en; step edge during halt=1 -> none.
REQ-036 RUN: pll_locked dropped -> sys_reset=1, ready=0, cpu_clk_en=0 within 3 edges, state=0.
REQ-037 step_btn held high across reset release into RUN -> zero strobes until released and re-pressed.
